uart_echo_ctl: RTL and testbench

Sequences the UART transmitter for echo/loopback operation. It sits between the UART receiver core and the UART transmitter core, and buffers received bytes in a small synchronous FIFO. When the transmitter is idle, it hands bytes to it using a start/busy handshake. It replaces the raw wire loopback with byte-level flow control and exposes overflow and timeout counters and monitor outputs for debug.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_fifo.sv | 38 +++
 rtl/uart_echo_ctl.sv | 71 +++++++
 tb/tb_uart_echo_ctl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types, constants and saturating-increment helper for the UART echo path
package uart_pkg;
   typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} echo_state_t;
   localparam int BYTE_W = 8;
   localparam logic [7:0] CNT_MAX = 8'hFF;
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == CNT_MAX) ? v : v + 8'd1;
   endfunction
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO with wrap-bit pointers; a pop frees a slot for a same-cycle push
module uart_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_din,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_dout,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0] r_wr_ptr, r_rd_ptr;
   logic w_wr, w_rd;
   assign o_level = r_wr_ptr - r_rd_ptr;
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (o_level == (AW+1)'(DEPTH));
   assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
   assign w_rd    = i_pop && !o_empty;
   assign w_wr    = i_push && (!o_full || w_rd);
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
   end
endmodule

// File: rtl/uart_echo_ctl.sv
// uart_echo_ctl: buffers received bytes and hands them to the transmitter via start/busy,
// with saturating overflow and handshake-timeout counters.
module uart_echo_ctl import uart_pkg::*; #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_loopback_enable,
   input  logic                    i_rx_valid,
   input  logic [BYTE_W-1:0]       i_rx_data,
   input  logic                    i_tx_busy,
   output logic                    o_tx_start,
   output logic [BYTE_W-1:0]       o_tx_data,
   output logic [$clog2(DEPTH):0]  o_fifo_level,
   output logic [7:0]              o_ovf_count,
   output logic [7:0]              o_tmo_count,
   output logic                    o_tx_active
);
   localparam int TW = $clog2(TIMEOUT);
   echo_state_t r_state, w_next;
   logic [TW-1:0] r_timer;
   logic [BYTE_W-1:0] w_head;
   logic w_push, w_pop, w_full, w_empty, w_tmo;
   assign w_push = i_rx_valid && i_loopback_enable;
   assign w_tmo  = (r_state == WAIT_BUSY) && !i_tx_busy && (r_timer == TW'(TIMEOUT - 1));
   uart_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_din   (i_rx_data),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (o_fifo_level)
   );
   always_ff @(posedge clk) begin
      r_state <= rst ? IDLE : w_next;
   end
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:      w_next = (!w_empty && !i_tx_busy) ? START : IDLE;
         START:     w_next = WAIT_BUSY;
         WAIT_BUSY: w_next = i_tx_busy ? WAIT_DONE : (w_tmo ? IDLE : WAIT_BUSY);
         WAIT_DONE: w_next = i_tx_busy ? WAIT_DONE : IDLE;
         default:   w_next = IDLE;
      endcase
   end
   always_comb begin
      w_pop       = (r_state == IDLE) && !w_empty && !i_tx_busy;
      o_tx_start  = (r_state == START);
      o_tx_active = (r_state != IDLE);
   end
   // A timed-out byte is simply abandoned; the FIFO already released it at the pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_tx_data   <= '0;
         r_timer     <= '0;
         o_ovf_count <= '0;
         o_tmo_count <= '0;
      end else begin
         if (w_pop) o_tx_data <= w_head;
         r_timer <= (r_state == START) ? '0 :
                    (r_state == WAIT_BUSY && !i_tx_busy) ? r_timer + TW'(1) : r_timer;
         if (w_push && w_full && !w_pop) o_ovf_count <= sat_inc(o_ovf_count);
         if (w_tmo) o_tmo_count <= sat_inc(o_tmo_count);
      end
   end
endmodule

// File: tb/tb_uart_echo_ctl.sv
// tb_uart_echo_ctl: directed echo scenarios; a monitor checks every tx_start byte against
// a queue of expected echoes while the main process checks levels, counters and timing.
module tb_uart_echo_ctl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic lb_en = 1'b0;
   logic rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic tx_busy;
   logic tx_start;
   logic [7:0] tx_data;
   logic [2:0] fifo_level;
   logic [7:0] ovf_count, tmo_count;
   logic tx_active;
   logic hold = 1'b0;
   logic mute = 1'b0;
   int busy_len = 20;
   int bcnt = 0;
   int n_vec = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];

   uart_echo_ctl #(.DEPTH(4), .TIMEOUT(16)) dut (
      .clk               (clk),
      .rst               (rst),
      .i_loopback_enable (lb_en),
      .i_rx_valid        (rx_valid),
      .i_rx_data         (rx_data),
      .i_tx_busy         (tx_busy),
      .o_tx_start        (tx_start),
      .o_tx_data         (tx_data),
      .o_fifo_level      (fifo_level),
      .o_ovf_count       (ovf_count),
      .o_tmo_count       (tmo_count),
      .o_tx_active       (tx_active)
   );

   always #5 clk = ~clk;

   // transmitter model: busy rises the cycle after tx_start and lasts busy_len cycles
   always @(posedge clk) begin
      if (tx_start && !mute) bcnt <= busy_len;
      else if (bcnt != 0) bcnt <= bcnt - 1;
   end
   assign tx_busy = hold || (bcnt != 0);

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (tx_start) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL tx_byte: unexpected tx_start with 0x%0h, none expected", tx_data);
         end else begin
            chk("tx_byte", int'(tx_data), int'(exp_q.pop_front()));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input bit expect_echo);
      rx_valid = 1'b1;
      rx_data = b;
      if (expect_echo) exp_q.push_back(b);
      tick(1);
      rx_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 400; i++) begin
         if (!tx_active && fifo_level == 0 && !tx_busy && exp_q.size() == 0) break;
         tick(1);
      end
      chk("drain_done", int'(i < 400), 1);
   endtask

   task automatic wait_start();
      int i;
      for (i = 0; i < 50; i++) begin
         if (tx_start) break;
         tick(1);
      end
      chk("start_seen", int'(i < 50), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int i;
      tick(2);
      rst = 1'b0;
      chk("rst_level", int'(fifo_level), 0);
      chk("rst_ovf", int'(ovf_count), 0);
      chk("rst_tmo", int'(tmo_count), 0);
      chk("rst_start", int'(tx_start), 0);
      chk("rst_active", int'(tx_active), 0);
      chk("rst_data", int'(tx_data), 0);

      lb_en = 1'b1;
      tick(8);
      send(8'h55, 1'b1);
      chk("single_level", int'(fifo_level), 1);
      tick(1);
      chk("single_start", int'(tx_start), 1);
      chk("single_data", int'(tx_data), 8'h55);
      tick(1);
      for (i = 0; i < 100; i++) begin
         if (!tx_busy) break;
         tick(1);
      end
      chk("single_active_at_fall", int'(tx_active), 1);
      tick(1);
      chk("single_active_after", int'(tx_active), 0);
      chk("single_level_end", int'(fifo_level), 0);

      busy_len = 3;
      hold = 1'b1;
      for (int k = 1; k <= 6; k++) send(8'(k), k <= 4);
      chk("burst_level", int'(fifo_level), 4);
      chk("burst_ovf", int'(ovf_count), 2);
      hold = 1'b0;
      wait_idle();
      chk("burst_ovf_after", int'(ovf_count), 2);

      hold = 1'b1;
      for (int k = 0; k < 4; k++) send(8'hB1 + 8'(k), 1'b1);
      chk("full_level", int'(fifo_level), 4);
      hold = 1'b0;
      send(8'hA0, 1'b1);
      chk("fullpop_level", int'(fifo_level), 4);
      chk("fullpop_ovf", int'(ovf_count), 2);
      wait_idle();

      do_reset();
      hold = 1'b1;
      send(8'hC1, 1'b1);
      send(8'hC2, 1'b1);
      lb_en = 1'b0;
      send(8'h7E, 1'b0);
      chk("disable_level", int'(fifo_level), 2);
      hold = 1'b0;
      wait_idle();
      chk("disable_ovf", int'(ovf_count), 0);

      do_reset();
      lb_en = 1'b1;
      mute = 1'b1;
      send(8'hD1, 1'b1);
      send(8'hD2, 1'b1);
      wait_start();
      tick(16);
      chk("tmo_before", int'(tmo_count), 0);
      chk("tmo_active_before", int'(tx_active), 1);
      tick(1);
      chk("tmo_first", int'(tmo_count), 1);
      chk("tmo_idle", int'(tx_active), 0);
      tick(1);
      chk("tmo_next_start", int'(tx_start), 1);
      chk("tmo_next_data", int'(tx_data), 8'hD2);
      tick(17);
      chk("tmo_second", int'(tmo_count), 2);
      mute = 1'b0;
      wait_idle();

      busy_len = 30;
      send(8'hE1, 1'b1);
      wait_start();
      tick(3);
      send(8'hE2, 1'b0);
      send(8'hE3, 1'b0);
      send(8'hE4, 1'b0);
      chk("midrst_level_before", int'(fifo_level), 3);
      chk("midrst_active_before", int'(tx_active), 1);
      do_reset();
      chk("midrst_level", int'(fifo_level), 0);
      chk("midrst_start", int'(tx_start), 0);
      chk("midrst_active", int'(tx_active), 0);
      chk("midrst_ovf", int'(ovf_count), 0);
      chk("midrst_tmo", int'(tmo_count), 0);
      chk("midrst_data", int'(tx_data), 0);
      tick(40);
      chk("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
